// File: rtl/brew_pkg.sv
// Shared types and recipe table for the brew sequencer.
package brew_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_RUN,
        ST_DONE,
        ST_FAULT
    } state_t;

    localparam logic [1:0] PH_GRIND = 2'd0;
    localparam logic [1:0] PH_HEAT  = 2'd1;
    localparam logic [1:0] PH_BREW  = 2'd2;

    // Seconds per phase; a zero entry means the phase is skipped.
    function automatic logic [1:0] recipe_dur(input logic [1:0] kind, input logic [1:0] ph);
        logic [5:0] row;
        logic [1:0] dur;
        case (kind)
            2'd0:    row = {2'd1, 2'd2, 2'd1};
            2'd1:    row = {2'd1, 2'd2, 2'd3};
            2'd2:    row = {2'd2, 2'd3, 2'd2};
            default: row = {2'd0, 2'd1, 2'd3};
        endcase
        case (ph)
            PH_GRIND: dur = row[5:4];
            PH_HEAT:  dur = row[3:2];
            default:  dur = row[1:0];
        endcase
        return dur;
    endfunction

endpackage

// File: rtl/brew_watchdog.sv
// Cycle-count watchdog guarding one timed phase against a timer that never expires.
module brew_watchdog #(
    parameter int WDOG_MAX = 500000000,
    parameter int WDOG_W   = 29
) (
    input  logic clk_100MHz,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    logic [WDOG_W-1:0] count;

    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + WDOG_W'(1);
        end
    end

    // Fires on the WDOG_MAX-th enabled cycle after a clear.
    assign expire = enable && (count == WDOG_W'(WDOG_MAX - 1));

endmodule

// File: rtl/brew_sequencer.sv
// Coffee maker brew controller: sequences GRIND/HEAT/BREW through the external timer.
//
// state | meaning
// IDLE  | waiting for a start_btn rising edge
// ARM   | value holds current phase duration; pulse timer or skip a zero phase
// RUN   | actuators on for current phase, waiting for t_expired or watchdog
// DONE  | one-cycle completion pulse
// FAULT | watchdog tripped; actuators off until cancel
module brew_sequencer
    import brew_pkg::*;
#(
    parameter int WDOG_MAX = 500000000,
    parameter int WDOG_W   = 29
) (
    input  logic       clk_100MHz,
    input  logic       rst_n,
    input  logic       start_btn,
    input  logic       cancel,
    input  logic [1:0] coffee_type,
    input  logic       t_expired,
    output logic [1:0] value,
    output logic       start_timer,
    output logic       grinder_on,
    output logic       heater_on,
    output logic       pump_on,
    output logic       busy,
    output logic       done,
    output logic       fault,
    output logic [1:0] phase
);

    state_t     state, state_nx;
    logic [1:0] phase_nx;
    logic [1:0] recipe, recipe_nx;
    logic [1:0] value_nx;
    logic       start_btn_q;
    logic       start_edge;
    logic       wd_clear;
    logic       wd_expire;

    assign start_edge = start_btn & ~start_btn_q;

    brew_watchdog #(
        .WDOG_MAX (WDOG_MAX),
        .WDOG_W   (WDOG_W)
    ) u_watchdog (
        .clk_100MHz (clk_100MHz),
        .rst_n      (rst_n),
        .clear      (wd_clear),
        .enable     (state == ST_RUN),
        .expire     (wd_expire)
    );

    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            phase       <= PH_GRIND;
            recipe      <= 2'd0;
            value       <= 2'd0;
            start_btn_q <= 1'b0;
        end else begin
            state       <= state_nx;
            phase       <= phase_nx;
            recipe      <= recipe_nx;
            value       <= value_nx;
            start_btn_q <= start_btn;
        end
    end

    always_comb begin
        state_nx    = state;
        phase_nx    = phase;
        recipe_nx   = recipe;
        value_nx    = value;
        wd_clear    = 1'b0;
        start_timer = 1'b0;

        case (state)
            ST_IDLE: begin
                if (!cancel && start_edge) begin
                    recipe_nx = coffee_type;
                    phase_nx  = PH_GRIND;
                    state_nx  = ST_ARM;
                end
            end
            ST_ARM: begin
                if (cancel) begin
                    state_nx = ST_IDLE;
                    phase_nx = PH_GRIND;
                end else if (value == 2'd0) begin
                    if (phase != PH_BREW) begin
                        phase_nx = phase + 2'd1;
                    end else begin
                        state_nx = ST_DONE;
                    end
                end else begin
                    start_timer = 1'b1;
                    wd_clear    = 1'b1;
                    state_nx    = ST_RUN;
                end
            end
            ST_RUN: begin
                if (cancel) begin
                    state_nx = ST_IDLE;
                    phase_nx = PH_GRIND;
                end else if (wd_expire) begin
                    state_nx = ST_FAULT;
                end else if (t_expired) begin
                    if (phase != PH_BREW) begin
                        phase_nx = phase + 2'd1;
                        state_nx = ST_ARM;
                    end else begin
                        state_nx = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_nx = ST_IDLE;
                phase_nx = PH_GRIND;
            end
            ST_FAULT: begin
                if (cancel) begin
                    state_nx = ST_IDLE;
                    phase_nx = PH_GRIND;
                end
            end
            default: begin
                state_nx = ST_IDLE;
                phase_nx = PH_GRIND;
            end
        endcase

        // value is ready on the first ARM cycle of every phase, including skipped ones.
        if (state_nx == ST_ARM) begin
            value_nx = recipe_dur(recipe_nx, phase_nx);
        end
    end

    assign grinder_on = (state == ST_RUN) && (phase == PH_GRIND);
    assign heater_on  = (state == ST_RUN) && ((phase == PH_HEAT) || (phase == PH_BREW));
    assign pump_on    = (state == ST_RUN) && (phase == PH_BREW);
    assign busy       = (state == ST_ARM) || (state == ST_RUN) || (state == ST_DONE);
    assign done       = (state == ST_DONE);
    assign fault      = (state == ST_FAULT);

endmodule

// File: tb/tb_brew_sequencer.sv
// Randomized bench for brew_sequencer: timer stub plus a recipe-table reference model.
module tb_brew_sequencer;

    localparam int WDOG_MAX = 20;
    localparam int WDOG_W   = 5;

    logic       clk_100MHz = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_btn = 1'b0;
    logic       cancel = 1'b0;
    logic [1:0] coffee_type = 2'd0;
    logic       t_expired = 1'b0;
    logic [1:0] value;
    logic       start_timer;
    logic       grinder_on;
    logic       heater_on;
    logic       pump_on;
    logic       busy;
    logic       done;
    logic       fault;
    logic [1:0] phase;

    always #5 clk_100MHz = ~clk_100MHz;

    brew_sequencer #(
        .WDOG_MAX (WDOG_MAX),
        .WDOG_W   (WDOG_W)
    ) dut (
        .clk_100MHz  (clk_100MHz),
        .rst_n       (rst_n),
        .start_btn   (start_btn),
        .cancel      (cancel),
        .coffee_type (coffee_type),
        .t_expired   (t_expired),
        .value       (value),
        .start_timer (start_timer),
        .grinder_on  (grinder_on),
        .heater_on   (heater_on),
        .pump_on     (pump_on),
        .busy        (busy),
        .done        (done),
        .fault       (fault),
        .phase       (phase)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // (grind, heat, brew) seconds per coffee type
    int dur_tab [4][3] = '{'{1, 2, 1}, '{1, 2, 3}, '{2, 3, 2}, '{0, 1, 3}};

    int exp_val [$];
    int exp_ph  [$];
    int got_val [$];
    int got_ph  [$];
    int pidx       = 0;
    int tmr_cnt    = 0;
    int run_left   = 0;
    int run_phase  = 0;
    int stub_delay = 5;
    int done_seen  = 0;
    bit no_expire  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [2:0] act_exp(input int ph);
        case (ph)
            0:       return 3'b100;
            1:       return 3'b010;
            2:       return 3'b011;
            default: return 3'b111;
        endcase
    endfunction

    task automatic plan(input int ty);
        exp_val.delete();
        exp_ph.delete();
        got_val.delete();
        got_ph.delete();
        pidx = 0;
        for (int p = 0; p < 3; p++) begin
            if (dur_tab[ty][p] != 0) begin
                exp_val.push_back(dur_tab[ty][p]);
                exp_ph.push_back(p);
            end
        end
    endtask

    function automatic logic [10:0] all_outs();
        return {value, start_timer, grinder_on, heater_on, pump_on, busy, done, fault, phase};
    endfunction

    // One clock: sample after the edge, run the timer stub, check actuators.
    task automatic tick();
        @(posedge clk_100MHz);
        #1;
        if (t_expired) t_expired = 1'b0;
        if (tmr_cnt > 0) begin
            tmr_cnt--;
            if (tmr_cnt == 0) t_expired = 1'b1;
        end
        if (run_left > 0) begin
            chk("act_run", {grinder_on, heater_on, pump_on}, act_exp(run_phase));
            run_left--;
        end else begin
            chk("act_off", {grinder_on, heater_on, pump_on}, 3'b000);
        end
        if (done) done_seen++;
        if (start_timer) begin
            got_val.push_back(int'(value));
            got_ph.push_back(int'(phase));
            run_phase = (pidx < exp_ph.size()) ? exp_ph[pidx] : -1;
            pidx++;
            run_left = no_expire ? WDOG_MAX : stub_delay;
            tmr_cnt  = no_expire ? 0 : stub_delay;
        end
    endtask

    task automatic cmp_pulses();
        chk("n_pulses", got_val.size(), exp_val.size());
        for (int k = 0; k < got_val.size() && k < exp_val.size(); k++) begin
            chk("pulse_value", got_val[k], exp_val[k]);
            chk("pulse_phase", got_ph[k], exp_ph[k]);
        end
    endtask

    task automatic brew(input int ty, input bit poke);
        int d0;
        plan(ty);
        d0 = done_seen;
        coffee_type = 2'(ty);
        start_btn = 1'b1;
        for (int i = 0; i < 200 && done_seen == d0; i++) begin
            tick();
            if (poke && done_seen == d0 && i == 3) start_btn = 1'b0;
            if (poke && done_seen == d0 && i == 4) begin
                start_btn   = 1'b1;
                coffee_type = 2'((ty + 1) % 4);
            end
        end
        chk("done_count", done_seen - d0, 1);
        tick();
        chk("busy_after_done", busy, 1'b0);
        chk("done_one_cycle", done, 1'b0);
        chk("no_fault", fault, 1'b0);
        cmp_pulses();
        start_btn = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("held_no_restart", {busy, 1'(got_val.size() == exp_val.size())}, 2'b01);
        start_btn = 1'b0;
        tick();
    endtask

    initial begin
        #1;
        chk("reset_outs", all_outs(), 11'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        stub_delay = 5;
        brew(0, 1'b0);
        stub_delay = 3;
        brew(3, 1'b0);

        // cancel during BREW RUN
        plan(1);
        stub_delay = 4;
        coffee_type = 2'd1;
        start_btn = 1'b1;
        tick();
        start_btn = 1'b0;
        for (int i = 0; i < 200 && pidx < 3; i++) tick();
        chk("reach_brew", pidx, 3);
        tick();
        tick();
        cancel = 1'b1;
        tmr_cnt = 0;
        run_left = 0;
        begin
            int d0;
            d0 = done_seen;
            tick();
            cancel = 1'b0;
            chk("cancel_idle", {busy, fault}, 2'b00);
            for (int i = 0; i < 8; i++) tick();
            chk("cancel_no_done", done_seen - d0, 0);
            chk("cancel_no_pulse", pidx, 3);
        end
        stub_delay = 2;
        brew(1, 1'b0);

        // t_expired and cancel together: cancel wins
        plan(2);
        stub_delay = 3;
        coffee_type = 2'd2;
        start_btn = 1'b1;
        tick();
        start_btn = 1'b0;
        for (int i = 0; i < 200 && !t_expired; i++) tick();
        chk("stub_expired", t_expired, 1'b1);
        cancel = 1'b1;
        tmr_cnt = 0;
        run_left = 0;
        begin
            int d0;
            d0 = done_seen;
            tick();
            cancel = 1'b0;
            chk("simul_idle", {busy, fault}, 2'b00);
            for (int i = 0; i < 8; i++) tick();
            chk("simul_no_pulse", pidx, 1);
            chk("simul_no_done", done_seen - d0, 0);
        end

        // watchdog with a timer that never expires
        no_expire = 1'b1;
        plan(0);
        coffee_type = 2'd0;
        start_btn = 1'b1;
        tick();
        start_btn = 1'b0;
        for (int i = 0; i < 50 && pidx < 1; i++) tick();
        chk("wd_pulse", pidx, 1);
        for (int i = 0; i < WDOG_MAX; i++) tick();
        chk("wd_not_yet", fault, 1'b0);
        tick();
        chk("wd_fault", {fault, busy}, 2'b10);
        coffee_type = 2'd2;
        start_btn = 1'b1;
        tick();
        tick();
        start_btn = 1'b0;
        chk("fault_ignores_start", {fault, busy}, 2'b10);
        chk("fault_no_pulse", pidx, 1);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        chk("cancel_clears_fault", {fault, busy}, 2'b00);
        no_expire = 1'b0;
        tick();

        // async reset mid-RUN
        plan(1);
        stub_delay = 6;
        coffee_type = 2'd1;
        start_btn = 1'b1;
        tick();
        start_btn = 1'b0;
        for (int i = 0; i < 200 && pidx < 2; i++) tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outs", all_outs(), 11'd0);
        run_left = 0;
        tmr_cnt = 0;
        t_expired = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        for (int n = 0; n < 24; n++) begin
            stub_delay = $urandom_range(1, 6);
            brew($urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
